mod_keygen: RTL and testbench
=============================

Name: mod_keygen

Overview:
- AES-256 key-expansion engine for the AES256 IP core.
- After reset it captures a 256-bit cipher key as eight 32-bit words on eight consecutive clocks, then expands it to the 60-word schedule w[0..59] at one word per clock.
- It then streams the 15 round keys, one per clock, to the cipher datapath.
- There is no handshake: downstream logic relies on the fixed latency defined below.

Parameters:
- Nk, 8, key length in 32-bit words (fixed for AES-256).
- Nr, 14, number of rounds; Nr+1 = 15 round keys.
- Nb, 4, state width in 32-bit words; one round key is Nb words.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- resetn  input  1  reset; asynchronous, active-low.
- kg_dataIn  input  32  key word; first byte is in bits [31:24].
- kg_dataOut  output  [Nr+1:0][7:0] (128)  current round key; byte [15] is the first byte of w[4k].

Behaviour:
- Reset (resetn=0, asynchronous):
  - kg_dataOut=0, word counter=0, round-key index=0, state=LOAD.
  - The schedule RAM/registers need not be cleared.
- Edge n counts rising edges with resetn=1 after reset release, starting at n=1.
- LOAD, edges 1..8:
  - w[n-1] <= kg_dataIn.
  - kg_dataIn is sampled at the edge; the driver changes it after the edge.
  - After edge 8, go to EXPAND.
- EXPAND, edges 9..60: one word per edge, i = 8..59.
  - temp = w[i-1].
  - If i mod 8 == 0: temp = SubWord(RotWord(temp)) ^ {Rcon[i/8],24'h0}.
  - Else if i mod 8 == 4: temp = SubWord(temp).
  - w[i] = w[i-8] ^ temp.
  - RotWord: {b1,b2,b3,b0}. SubWord: AES S-box applied to each byte.
  - Rcon[1..7] = 01,02,04,08,10,20,40.
  - After w[59] is written, go to OUTPUT.
- OUTPUT, edges 61..75:
  - kg_dataOut <= {w[4k],w[4k+1],w[4k+2],w[4k+3]} for k = 0..14.
  - Registered output: round key k is visible from edge 61+k.
  - After k=14, go to DONE.
- DONE:
  - kg_dataOut holds round key 14.
  - kg_dataIn is ignored.
  - Only reset restarts the sequence.
- kg_dataOut stays 0 during LOAD and EXPAND.
- kg_dataIn is ignored in every state except LOAD.
- Reset asserted mid-LOAD, mid-EXPAND or mid-OUTPUT aborts immediately and restarts at LOAD; partially loaded words are discarded.
- Counter widths: word index 6 bits (0..59); round-key index 4 bits (0..14), with no wrap past 14.

Decomposition:
- Shared package aes_pkg holds:
  - localparams Nk=8, Nr=14, Nb=4;
  - the Rcon constant array;
  - a word_t typedef ([3:0][7:0]);
  - an enum state_t {LOAD, EXPAND, OUTPUT, DONE}.
- One sub-module, aes_sbox: combinational 8-bit S-box lookup.
  - Instantiate four of them for SubWord; the RotWord/Rcon muxing stays in mod_keygen.

Test Plan:
1. FIPS-197 C.3 key 00010203..1c1d1e1f, one word per clock after reset:
   - edge 61 round key 0 = 000102030405060708090a0b0c0d0e0f;
   - edge 62 round key 1 = 101112131415161718191a1b1c1d1e1f;
   - edge 63 round key 2 = a573c29fa176c498a97fce93a572c09c;
   - edge 75 round key 14 = 24fc79ccbf0979e9371ac23c6d68de36.
2. Key 000102030405060708090a0b0c0d0e0f repeated twice:
   - round keys 0 and 1 both = 000102030405060708090a0b0c0d0e0f;
   - w[8] = d6aa74fd.
3. FIPS-197 A.3 key 603deb10..0914dff4: w[8] = 9ba35411 (top word of round key 2); also check w[12] = a8b09c1a, from the i mod 8 == 4 SubWord path.
4. Before edge 61, and after reset, kg_dataOut = 0; after edge 75 it holds round key 14 for 100 further cycles while kg_dataIn toggles randomly.
5. Assert resetn during EXPAND (edge 30), then reload the C.3 key:
   - kg_dataOut goes to 0 immediately (asynchronous);
   - the full sequence repeats with identical round keys at edges 61..75 after release.
6. Change kg_dataIn during OUTPUT/DONE: round keys are unchanged versus scenario 1.

Source files
------------

// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared definitions for the AES-256 key-expansion engine.
//   Nk, Nr, Nb : AES-256 geometry (key words, rounds, state words)
//   NW         : number of words in the expanded schedule, Nb*(Nr+1)
//   Rcon       : round constants, indexed by i/Nk (entry 0 is unused)
//   word_t     : 32-bit word as four bytes; byte [3] is the first byte
//   state_t    : key-generator sequencing states
// -----------------------------------------------------------------------------
package aes_pkg;

    localparam int Nk = 8;
    localparam int Nr = 14;
    localparam int Nb = 4;
    localparam int NW = Nb * (Nr + 1);

    localparam logic [0:7][7:0] Rcon = {
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40
    };

    typedef logic [3:0][7:0] word_t;

    typedef enum logic [1:0] {
        LOAD,
        EXPAND,
        OUTPUT,
        DONE
    } state_t;

endpackage

// File: rtl/aes_sbox.sv
// -----------------------------------------------------------------------------
// aes_sbox
// Combinational AES forward S-box lookup.
//   i_byte : input byte
//   o_byte : substituted byte
// -----------------------------------------------------------------------------
module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    always_comb begin
        o_byte = SBOX[i_byte];
    end

endmodule

// File: rtl/mod_keygen.sv
// -----------------------------------------------------------------------------
// mod_keygen
// AES-256 key expansion. Loads the 256-bit cipher key one word per clock,
// expands it to the 60-word schedule one word per clock, then streams the 15
// round keys one per clock and holds the last one. No handshake: consumers
// rely on the fixed timing (round key k registered at edge 61+k after reset).
//   clk        : clock, rising edge
//   resetn     : asynchronous active-low reset, restarts at LOAD
//   kg_dataIn  : key word during LOAD, first byte in [31:24]
//   kg_dataOut : current round key; byte [15] is the first byte of w[4k]
// -----------------------------------------------------------------------------
module mod_keygen
    import aes_pkg::*;
(
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [31:0]           kg_dataIn,
    output logic [Nr+1:0][7:0]    kg_dataOut
);

    state_t      r_state;
    logic [5:0]  r_widx;
    logic [3:0]  r_kidx;
    word_t       r_w [0:NW-1];

    logic [5:0]         w_im1;
    logic [5:0]         w_im8;
    word_t              w_prev;
    word_t              w_rot;
    word_t              w_sub_in;
    word_t              w_sub;
    word_t              w_temp;
    word_t              w_next;
    logic [Nr+1:0][7:0] w_rk;

    assign w_im1 = r_widx - 6'd1;
    assign w_im8 = r_widx - 6'd8;

    // Schedule recurrence for word i = r_widx. The same four S-boxes serve
    // both the i%8==0 (after RotWord) and i%8==4 (plain SubWord) cases.
    always_comb begin
        w_prev   = r_w[w_im1];
        w_rot    = {w_prev[2:0], w_prev[3]};
        w_sub_in = (r_widx[2:0] == 3'd0) ? w_rot : w_prev;
        case (r_widx[2:0])
            3'd0:    w_temp = w_sub ^ {Rcon[r_widx[5:3]], 24'h000000};
            3'd4:    w_temp = w_sub;
            default: w_temp = w_prev;
        endcase
        w_next = r_w[w_im8] ^ w_temp;
    end

    for (genvar g = 0; g < 4; g++) begin : g_sub
        aes_sbox u_sbox (
            .i_byte (w_sub_in[g]),
            .o_byte (w_sub[g])
        );
    end

    always_comb begin
        w_rk = {r_w[{r_kidx, 2'd0}], r_w[{r_kidx, 2'd1}],
                r_w[{r_kidx, 2'd2}], r_w[{r_kidx, 2'd3}]};
    end

    // Schedule storage carries no reset; every word is rewritten before use.
    always_ff @(posedge clk) begin
        if (r_state == LOAD) begin
            r_w[r_widx] <= kg_dataIn;
        end else if (r_state == EXPAND) begin
            r_w[r_widx] <= w_next;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= LOAD;
            r_widx     <= '0;
            r_kidx     <= '0;
            kg_dataOut <= '0;
        end else begin
            case (r_state)
                LOAD: begin
                    r_widx <= r_widx + 6'd1;
                    if (r_widx == 6'd7) begin
                        r_state <= EXPAND;
                    end
                end
                EXPAND: begin
                    if (r_widx == 6'(NW - 1)) begin
                        r_state <= OUTPUT;
                        r_kidx  <= '0;
                    end else begin
                        r_widx <= r_widx + 6'd1;
                    end
                end
                OUTPUT: begin
                    kg_dataOut <= w_rk;
                    if (r_kidx == 4'(Nr)) begin
                        r_state <= DONE;
                    end else begin
                        r_kidx <= r_kidx + 4'd1;
                    end
                end
                DONE: begin
                    r_state <= DONE;
                end
                default: begin
                    r_state <= LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mod_keygen.sv
// -----------------------------------------------------------------------------
// tb_mod_keygen
// Scoreboarded bench for mod_keygen. Stimulus queues the expected value of
// kg_dataOut for a given edge count (or for an immediate check right after an
// asynchronous reset); a monitor compares whenever that point is reached.
// -----------------------------------------------------------------------------
module tb_mod_keygen;
    import aes_pkg::*;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic [31:0]  kg_dataIn = '0;
    logic [127:0] kg_dataOut;

    mod_keygen u_dut (
        .clk        (clk),
        .resetn     (resetn),
        .kg_dataIn  (kg_dataIn),
        .kg_dataOut (kg_dataOut)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           edge_no;   // -1: check right after asynchronous reset
        logic [127:0] val;
        logic [127:0] mask;
        string        name;
    } exp_t;

    exp_t sb[$];
    int   cnt;
    int   n_checks = 0;
    int   n_pass = 0;
    bit   async_req = 1'b0;
    event ev_chk;

    localparam logic [127:0] FULL = '1;
    localparam logic [127:0] TOP  = {32'hffffffff, 96'h0};

    localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KEY_RP = {2{128'h000102030405060708090a0b0c0d0e0f}};
    localparam logic [255:0] KEY_A3 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    localparam logic [127:0] C3_RK0  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C3_RK1  = 128'h101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] C3_RK2  = 128'ha573c29fa176c498a97fce93a572c09c;
    localparam logic [127:0] C3_RK14 = 128'h24fc79ccbf0979e9371ac23c6d68de36;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) cnt <= 0;
        else         cnt <= cnt + 1;
    end

    task automatic expect_at(input int e, input logic [127:0] v,
                             input logic [127:0] m, input string nm);
        exp_t x;
        x.edge_no = e;
        x.val     = v;
        x.mask    = m;
        x.name    = nm;
        sb.push_back(x);
    endtask

    task automatic check_entry(input exp_t x);
        n_checks++;
        if ((kg_dataOut & x.mask) === (x.val & x.mask)) begin
            n_pass++;
        end else begin
            $display("FAIL %s (edge %0d): got %h expected %h mask %h",
                     x.name, x.edge_no, kg_dataOut, x.val, x.mask);
        end
    endtask

    // Monitor
    initial begin
        exp_t x;
        forever begin
            @(negedge clk or ev_chk);
            while (sb.size() > 0) begin
                if (sb[0].edge_no < 0) begin
                    if (!async_req) break;
                    async_req = 1'b0;
                end else begin
                    if (async_req || !resetn || sb[0].edge_no > cnt) break;
                    if (sb[0].edge_no < cnt) begin
                        x = sb.pop_front();
                        n_checks++;
                        $display("FAIL %s: edge %0d not sampled (now %0d)",
                                 x.name, x.edge_no, cnt);
                        continue;
                    end
                end
                x = sb.pop_front();
                check_entry(x);
            end
        end
    end

    // Reset, load key, keep driving random words until last_edge, then
    // optionally assert reset and request an immediate zero check.
    task automatic run(input logic [255:0] key, input int last_edge,
                       input bit abort, input string nm);
        resetn    = 1'b0;
        kg_dataIn = '0;
        repeat (2) @(posedge clk);
        #2;
        resetn    = 1'b1;
        kg_dataIn = key[255 -: 32];
        for (int j = 1; j < 8; j++) begin
            @(posedge clk);
            #1 kg_dataIn = key[255 - 32*j -: 32];
        end
        for (int e = 8; e <= last_edge; e++) begin
            @(posedge clk);
            #1 kg_dataIn = $urandom;
        end
        @(negedge clk);
        #1;
        if (abort) begin
            resetn = 1'b0;
            #1;
            async_req = 1'b1;
            ->ev_chk;
            #1;
        end
        n_checks++;
        if (sb.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL %s_drain: got %0d pending expected 0", nm, sb.size());
        end
        sb.delete();
        async_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        // C.3 key, full sequence, then 100 DONE cycles with random input
        expect_at(0,  '0, FULL, "c3_reset_zero");
        expect_at(8,  '0, FULL, "c3_load_zero");
        expect_at(9,  '0, FULL, "c3_expand_zero");
        expect_at(60, '0, FULL, "c3_pre_output_zero");
        expect_at(61, C3_RK0, FULL, "c3_rk0");
        expect_at(62, C3_RK1, FULL, "c3_rk1");
        expect_at(63, C3_RK2, FULL, "c3_rk2");
        expect_at(75, C3_RK14, FULL, "c3_rk14");
        for (int e = 76; e <= 175; e++) expect_at(e, C3_RK14, FULL, "c3_done_hold");
        run(KEY_C3, 175, 1'b0, "c3");

        // Repeated 128-bit half
        expect_at(0,  '0, FULL, "rp_reset_zero");
        expect_at(61, 128'h000102030405060708090a0b0c0d0e0f, FULL, "rp_rk0");
        expect_at(62, 128'h000102030405060708090a0b0c0d0e0f, FULL, "rp_rk1");
        expect_at(63, {32'hd6aa74fd, 96'h0}, TOP, "rp_w8");
        run(KEY_RP, 63, 1'b0, "rp");

        // A.3 key: Rcon path (w8) and SubWord-only path (w12)
        expect_at(61, 128'h603deb1015ca71be2b73aef0857d7781, FULL, "a3_rk0");
        expect_at(62, 128'h1f352c073b6108d72d9810a30914dff4, FULL, "a3_rk1");
        expect_at(63, {32'h9ba35411, 96'h0}, TOP, "a3_w8");
        expect_at(64, {32'ha8b09c1a, 96'h0}, TOP, "a3_w12");
        run(KEY_A3, 64, 1'b0, "a3");

        // Abort during EXPAND, then full rerun of C.3
        expect_at(0,  '0, FULL, "ab_reset_zero");
        expect_at(30, '0, FULL, "ab_expand_zero");
        expect_at(-1, '0, FULL, "ab_expand_async_zero");
        run(KEY_C3, 30, 1'b1, "ab_expand");
        expect_at(0,  '0, FULL, "re_reset_zero");
        expect_at(60, '0, FULL, "re_pre_output_zero");
        expect_at(61, C3_RK0, FULL, "re_rk0");
        expect_at(62, C3_RK1, FULL, "re_rk1");
        expect_at(63, C3_RK2, FULL, "re_rk2");
        expect_at(75, C3_RK14, FULL, "re_rk14");
        expect_at(80, C3_RK14, FULL, "re_done_hold");
        run(KEY_C3, 80, 1'b0, "re");

        // Abort during OUTPUT: nonzero round key must clear at once
        expect_at(61, C3_RK0, FULL, "ao_rk0");
        expect_at(62, C3_RK1, FULL, "ao_rk1");
        expect_at(63, C3_RK2, FULL, "ao_rk2");
        expect_at(-1, '0, FULL, "ao_async_zero");
        run(KEY_C3, 63, 1'b1, "ab_output");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
